// File: rtl/sram_access_controller.sv
// sram_access_controller
// Sequences 68000 bus cycles aimed at the 256 KB on-chip SRAM (four 64 KB
// blocks). A cycle starts from IDLE once AS, the SRAM decode and at least one
// data strobe are seen. It then runs SETUP -> ACCESS (WAIT_STATES cycles) ->
// ACK and holds Dtack until AS is released.
//
// Parameters:
//   WAIT_STATES   number of ACCESS cycles before DTACK (legal 1..15)
// Ports:
//   Clock         system clock, rising edge
//   Reset_L       synchronous active-low reset
//   AS_L          68k address strobe
//   UDS_L, LDS_L  68k upper/lower data strobes
//   WE_L          68k R/W (1 = read, 0 = write)
//   SRamSelect_H  top-level decode: cycle targets SRAM
//   Block0_H..3_H 64 KB block selects from the block decoder
//   SRam_CE_L     per-block chip enables (bit n = block n)
//   SRam_UB_L/LB_L byte-lane enables
//   SRam_OE_L     output enable (reads)
//   SRam_WE_L     write enable (writes)
//   Dtack_L       data acknowledge to the 68k
//   SelError_H    sticky flag: a cycle started with non-one-hot block selects
module sram_access_controller #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic       Clock,
  input  logic       Reset_L,
  input  logic       AS_L,
  input  logic       UDS_L,
  input  logic       LDS_L,
  input  logic       WE_L,
  input  logic       SRamSelect_H,
  input  logic       Block0_H,
  input  logic       Block1_H,
  input  logic       Block2_H,
  input  logic       Block3_H,
  output logic [3:0] SRam_CE_L,
  output logic       SRam_UB_L,
  output logic       SRam_LB_L,
  output logic       SRam_OE_L,
  output logic       SRam_WE_L,
  output logic       Dtack_L,
  output logic       SelError_H
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               wr;

  logic [3:0] blocks_c;
  logic       one_hot_c;
  logic       start_c;

  // Request decode: writes naturally wait for the late data strobes
  assign blocks_c  = {Block3_H, Block2_H, Block1_H, Block0_H};
  assign one_hot_c = (blocks_c != 4'd0) && ((blocks_c & (blocks_c - 4'd1)) == 4'd0);
  assign start_c   = !AS_L && SRamSelect_H && (!UDS_L || !LDS_L);

  // Bus-cycle sequencer; the output registers double as the latched request
  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      state      <= IDLE;
      cnt        <= '0;
      wr         <= 1'b0;
      SRam_CE_L  <= 4'hF;
      SRam_UB_L  <= 1'b1;
      SRam_LB_L  <= 1'b1;
      SRam_OE_L  <= 1'b1;
      SRam_WE_L  <= 1'b1;
      Dtack_L    <= 1'b1;
      SelError_H <= 1'b0;
    end else if (state != IDLE && AS_L) begin
      // AS released: abort from SETUP/ACCESS, normal end from ACK
      state     <= IDLE;
      cnt       <= '0;
      SRam_CE_L <= 4'hF;
      SRam_UB_L <= 1'b1;
      SRam_LB_L <= 1'b1;
      SRam_OE_L <= 1'b1;
      SRam_WE_L <= 1'b1;
      Dtack_L   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_c) begin
            state     <= SETUP;
            // A bad select still runs the cycle so the CPU is not hung
            SRam_CE_L <= one_hot_c ? ~blocks_c : 4'hF;
            SRam_UB_L <= UDS_L;
            SRam_LB_L <= LDS_L;
            SRam_OE_L <= ~WE_L;
            wr        <= ~WE_L;
            if (!one_hot_c) begin
              SelError_H <= 1'b1;
            end
          end
        end
        SETUP: begin
          state     <= ACCESS;
          cnt       <= CNT_W'(WAIT_STATES - 1);
          SRam_WE_L <= ~wr;
        end
        ACCESS: begin
          if (cnt == '0) begin
            state     <= ACK;
            Dtack_L   <= 1'b0;
            // Write ends while CE is still low to give data hold
            SRam_WE_L <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ACK: begin
          state <= ACK;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_controller.sv
// Scoreboard bench for sram_access_controller. Stimulus pushes expected
// output snapshots tagged with the edge number after which they must hold;
// a monitor compares them on the falling edge. Two instances share inputs:
// dut0 with WAIT_STATES=2, dut1 with WAIT_STATES=1.
module tb_sram_access_controller;

  logic clk;
  logic rst_l;
  logic as_l, uds_l, lds_l, we_l, sel;
  logic [3:0] blk;

  logic [3:0] ce0, ce1;
  logic ub0, lb0, oe0, we0, dt0, se0;
  logic ub1, lb1, oe1, we1, dt1, se1;

  int unsigned cyc;
  int checks;
  int errors;

  typedef struct {
    int unsigned at;
    bit          d;
    logic [9:0]  v;
    string       nm;
  } exp_t;

  exp_t q[$];

  sram_access_controller #(.WAIT_STATES(2)) dut0 (
    .Clock(clk), .Reset_L(rst_l), .AS_L(as_l), .UDS_L(uds_l), .LDS_L(lds_l),
    .WE_L(we_l), .SRamSelect_H(sel),
    .Block0_H(blk[0]), .Block1_H(blk[1]), .Block2_H(blk[2]), .Block3_H(blk[3]),
    .SRam_CE_L(ce0), .SRam_UB_L(ub0), .SRam_LB_L(lb0), .SRam_OE_L(oe0),
    .SRam_WE_L(we0), .Dtack_L(dt0), .SelError_H(se0)
  );

  sram_access_controller #(.WAIT_STATES(1)) dut1 (
    .Clock(clk), .Reset_L(rst_l), .AS_L(as_l), .UDS_L(uds_l), .LDS_L(lds_l),
    .WE_L(we_l), .SRamSelect_H(sel),
    .Block0_H(blk[0]), .Block1_H(blk[1]), .Block2_H(blk[2]), .Block3_H(blk[3]),
    .SRam_CE_L(ce1), .SRam_UB_L(ub1), .SRam_LB_L(lb1), .SRam_OE_L(oe1),
    .SRam_WE_L(we1), .Dtack_L(dt1), .SelError_H(se1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int unsigned at, input bit d,
                               input logic [3:0] ce, input logic ub, input logic lb,
                               input logic oe, input logic we, input logic dt,
                               input logic se, input string nm);
    exp_t e;
    e.at = at;
    e.d  = d;
    e.v  = {ce, ub, lb, oe, we, dt, se};
    e.nm = nm;
    q.push_back(e);
  endfunction

  // Monitor: compare every snapshot due at this edge count
  always @(negedge clk) begin : monitor
    logic [9:0] o;
    for (int i = int'(q.size()) - 1; i >= 0; i--) begin
      if (q[i].at <= cyc) begin
        o = q[i].d ? {ce1, ub1, lb1, oe1, we1, dt1, se1}
                   : {ce0, ub0, lb0, oe0, we0, dt0, se0};
        checks++;
        if (q[i].at != cyc || o !== q[i].v) begin
          errors++;
          $display("FAIL %s dut%0d edge %0d: got ce,ub,lb,oe,we,dtack,selerr=%b expected %b",
                   q[i].nm, q[i].d, q[i].at, o, q[i].v);
        end
        q.delete(i);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    as_l = 1'b1; uds_l = 1'b1; lds_l = 1'b1; we_l = 1'b1; sel = 1'b0; blk = 4'd0;
  endtask

  // One complete bus cycle on dut d; hold = extra ACK samples before AS release
  task automatic bus_cycle(input bit d, input logic [3:0] blk_v, input logic u,
                           input logic l, input logic w, input bit ds_late,
                           input int unsigned hold, input logic [3:0] ce_exp,
                           input logic se_exp, input string nm);
    int unsigned s, ws, last;
    ws = d ? 1 : 2;
    as_l = 1'b0; sel = 1'b1; blk = blk_v; we_l = w; uds_l = 1'b1; lds_l = 1'b1;
    if (ds_late) begin
      push(cyc + 1, d, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, se_exp, {nm, "_nods"});
      step();
    end
    uds_l = u; lds_l = l;
    s = cyc + 1;
    last = s + ws + 1 + hold;
    for (int unsigned k = 0; k <= last - s; k++) begin
      push(s + k, d, ce_exp, u, l, !w,
           (k >= 1 && k <= ws && w == 1'b0) ? 1'b0 : 1'b1,
           (k >= ws + 1) ? 1'b0 : 1'b1, se_exp, nm);
    end
    while (cyc < last) step();
    idle_inputs();
    push(last + 1, d, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, se_exp, {nm, "_rel"});
    step();
  endtask

  initial begin : stim
    int unsigned s;
    checks = 0;
    errors = 0;
    rst_l = 1'b0;
    idle_inputs();

    // Reset values
    step(); step();
    push(cyc + 1, 0, 4'hF, 1, 1, 1, 1, 1, 0, "reset0");
    push(cyc + 1, 1, 4'hF, 1, 1, 1, 1, 1, 0, "reset1");
    step();
    rst_l = 1'b1;
    push(cyc + 1, 0, 4'hF, 1, 1, 1, 1, 1, 0, "idle_after_reset");
    step(); step();

    // Read, block 2, upper lane
    bus_cycle(0, 4'b0100, 1'b0, 1'b1, 1'b1, 0, 1, 4'b1011, 1'b0, "read_b2_ub");
    step();

    // Write, block 0, both lanes, strobes one cycle after AS
    bus_cycle(0, 4'b0001, 1'b0, 1'b0, 1'b0, 1, 0, 4'b1110, 1'b0, "write_b0");
    step();

    // Abort: AS rises during ACCESS on a write to block 3
    as_l = 1'b0; sel = 1'b1; blk = 4'b1000; we_l = 1'b0; uds_l = 1'b0; lds_l = 1'b1;
    s = cyc + 1;
    push(s,     0, 4'b0111, 0, 1, 1, 1, 1, 0, "abort_setup");
    push(s + 1, 0, 4'b0111, 0, 1, 1, 0, 1, 0, "abort_access");
    while (cyc < s + 1) step();
    idle_inputs();
    push(s + 2, 0, 4'hF, 1, 1, 1, 1, 1, 0, "abort_idle");
    push(s + 3, 0, 4'hF, 1, 1, 1, 1, 1, 0, "abort_no_dtack");
    step(); step(); step();

    // Select error: blocks 1 and 3 together
    bus_cycle(0, 4'b1010, 1'b0, 1'b0, 1'b1, 0, 0, 4'hF, 1'b1, "selerr");
    step();
    // Following good cycle keeps the sticky flag
    bus_cycle(0, 4'b0100, 1'b1, 1'b0, 1'b1, 0, 0, 4'b1011, 1'b1, "good_after_err");
    step();

    // Back-to-back reads on the WAIT_STATES=1 instance
    bus_cycle(1, 4'b0010, 1'b1, 1'b0, 1'b1, 0, 0, 4'b1101, 1'b1, "b2b_a");
    bus_cycle(1, 4'b1000, 1'b0, 1'b1, 1'b1, 0, 0, 4'b0111, 1'b1, "b2b_b");
    step(); step(); step();

    // Reset mid-write clears everything including the sticky flag
    as_l = 1'b0; sel = 1'b1; blk = 4'b0010; we_l = 1'b0; uds_l = 1'b0; lds_l = 1'b0;
    s = cyc + 1;
    push(s,     0, 4'b1101, 0, 0, 1, 1, 1, 1, "rst_wr_setup");
    push(s + 1, 0, 4'b1101, 0, 0, 1, 0, 1, 1, "rst_wr_access");
    while (cyc < s + 1) step();
    rst_l = 1'b0;
    push(s + 2, 0, 4'hF, 1, 1, 1, 1, 1, 0, "rst_mid_write");
    push(s + 3, 0, 4'hF, 1, 1, 1, 1, 1, 0, "rst_hold");
    push(s + 3, 1, 4'hF, 1, 1, 1, 1, 1, 0, "rst_hold_dut1");
    step(); step();
    rst_l = 1'b1;
    idle_inputs();
    push(cyc + 1, 0, 4'hF, 1, 1, 1, 1, 1, 0, "idle_after_rst");
    step(); step(); step();

    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
